stack_unit: RTL and testbench
=============================

Name: stack_unit

Overview:
- Memory-stage responder for the decode-stage stack commands: PUSH/POP of a 16-bit register or flags word, and PUSH/POP of a 32-bit PC (CALL, RET, RETI, interrupt entry).
- Owns the stack pointer (SP) and sequences 32-bit values as two 16-bit word accesses on the single-ported data memory.
- Signals completion with a one-cycle response pulse, and returns popped data.

Parameters:
- ADDR_W, 11, word-address width of data memory.
- STACK_TOP, 2047, SP reset value; empty-stack address (next free slot); stack grows downward.
- STACK_LIMIT, 1024, lowest word address the stack may write.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  command request.
- req_ready  out  1  unit can accept a command (high only in IDLE).
- req_op  in  2  00 PUSH16, 01 PUSH32, 10 POP16, 11 POP32.
- req_data  in  32  push data; PUSH16 uses [15:0].
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  qualifies rsp_valid: overflow or underflow, command dropped.
- rsp_data  out  32  pop result; POP16 zero-extended; holds value until next pop completes.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  16  write data.
- mem_we  out  1  write strobe, written at the rising edge.
- mem_re  out  1  read strobe.
- mem_rdata  in  16  read data, valid the cycle after mem_re (1-cycle synchronous read).
- sp  out  ADDR_W  current stack pointer, for debug.

Behaviour:
- Reset (async, reset==0):
  - state=IDLE, sp=STACK_TOP.
  - rsp_valid, rsp_err, mem_we and mem_re all 0; rsp_data=0.
  - A reset mid-operation abandons the command; partial writes remain in memory; no response is issued.
- States: IDLE, PUSH_HI, PUSH_LO, POP_RD0, POP_RD1, POP_DONE.
- Handshake: a command is accepted when req_valid && req_ready at a rising edge. Operands are latched at acceptance. req_ready=0 outside IDLE.
- Bounds check at acceptance, with n = words (1 or 2):
  - Push is legal iff sp - n + 1 >= STACK_LIMIT.
  - Pop is legal iff STACK_TOP - sp >= n.
  - Illegal: state stays IDLE, no memory access, sp unchanged; next cycle rsp_valid=1 and rsp_err=1.
- Push word cycle: mem_we=1, mem_addr=sp, then sp <= sp-1.
- Pop word cycle: mem_re=1, mem_addr=sp+1, then sp <= sp+1.
- Word order: PUSH32 writes [31:16] first (higher address), then [15:0]. POP32 reads low then high; rsp_data={high,low}.
- Transitions:
  - IDLE -> PUSH_LO (PUSH16); -> PUSH_HI (PUSH32); -> POP_RD1 (POP16); -> POP_RD0 (POP32).
  - PUSH_HI -> PUSH_LO -> IDLE.
  - POP_RD0 (read low) -> POP_RD1 (read high or single word; capture low word from the previous read) -> POP_DONE.
  - POP_DONE: capture mem_rdata, no memory strobe -> IDLE.
- rsp_valid is registered, rsp_err=0 on success. It pulses in the cycle after the last state (PUSH_LO or POP_DONE).
- Latency from acceptance edge to rsp_valid cycle: PUSH16 2, PUSH32 3, POP16 3, POP32 4, error 1.
- Back-to-back: a new command may be accepted in the cycle rsp_valid is high.
- rsp_data is updated only at the end of a successful pop.
- mem_we and mem_re are never both 1. mem_addr=sp when idle.
- Arithmetic is unsigned ADDR_W. The bounds check makes wrap impossible.

Test Plan:
- Reset, PUSH16 0x1234 -> mem[2047]=0x1234, sp=2046, rsp_valid 2 cycles after accept, rsp_err=0.
- PUSH32 0xAABB_CCDD from sp=2047 -> mem[2047]=0xAABB, mem[2046]=0xCCDD, sp=2045. Then POP32 -> rsp_data=0xAABBCCDD, sp=2047, latency 4.
- POP16 on empty stack (sp=2047) -> rsp_valid=rsp_err=1 next cycle, no mem_re, sp stays 2047.
- Fill to sp=1024, then PUSH32 -> error, no mem_we. PUSH16 -> writes mem[1024], sp=1023. Then PUSH16 -> error.
- Back-to-back PUSH16 0x0001, PUSH16 0x0002, POP16, POP16, with req_valid held high -> pops return 0x00000002 then 0x00000001; req_ready low except in IDLE.
- Assert reset during POP_RD1 of a POP32 -> sp=2047 immediately, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/stack_unit.sv
// Stack responder for decode-stage PUSH/POP commands: owns SP and splits
// 32-bit values into two 16-bit word accesses on a single-ported memory.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a command; bounds-checked at acceptance
// PUSH_HI  | write upper half of a 32-bit push at sp, sp--
// PUSH_LO  | write lower (or only) word at sp, sp--
// POP_RD0  | read low word of a 32-bit pop at sp+1, sp++
// POP_RD1  | read high (or only) word at sp+1, sp++; capture low word
// POP_DONE | capture last read word into rsp_data
module stack_unit #(
  parameter int ADDR_W      = 11,
  parameter int STACK_TOP   = 2047,
  parameter int STACK_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [31:0]       req_data,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [15:0]       mem_rdata,
  output logic [ADDR_W-1:0] sp
);

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH_HI, S_PUSH_LO, S_POP_RD0, S_POP_RD1, S_POP_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] SP_RST  = ADDR_W'(STACK_TOP);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  localparam logic [ADDR_W:0]   TOP_X   = (ADDR_W+1)'(STACK_TOP);
  localparam logic [ADDR_W:0]   LIMIT_X = (ADDR_W+1)'(STACK_LIMIT);
  localparam logic [ADDR_W:0]   ONE_X   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   TWO_X   = (ADDR_W+1)'(2);

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_sp;
  logic                r_wide;
  logic [31:0]         r_data;
  logic [15:0]         r_lo;
  logic                r_rsp_valid, r_rsp_err;
  logic [31:0]         r_rsp_data;

  logic [ADDR_W:0]     w_n, w_sp_x;
  logic                w_accept, w_push_ok, w_pop_ok, w_ok, w_done;

  // Bounds compares are done one bit wider and rearranged so nothing can wrap.
  assign w_n       = req_op[0] ? TWO_X : ONE_X;
  assign w_sp_x    = {1'b0, r_sp};
  assign w_push_ok = (w_sp_x + ONE_X) >= (LIMIT_X + w_n);
  assign w_pop_ok  = TOP_X >= (w_sp_x + w_n);
  assign w_ok      = req_op[1] ? w_pop_ok : w_push_ok;
  assign w_accept  = req_valid && (r_state == S_IDLE);

  always_comb begin
    w_next    = r_state;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = r_sp;
    mem_wdata = r_data[15:0];
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_ok) begin
          case (req_op)
            2'b00:   w_next = S_PUSH_LO;
            2'b01:   w_next = S_PUSH_HI;
            2'b10:   w_next = S_POP_RD1;
            default: w_next = S_POP_RD0;
          endcase
        end
      end
      S_PUSH_HI: begin
        mem_we    = 1'b1;
        mem_wdata = r_data[31:16];
        w_next    = S_PUSH_LO;
      end
      S_PUSH_LO: begin
        mem_we = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      S_POP_RD0: begin
        mem_re   = 1'b1;
        mem_addr = r_sp + ONE;
        w_next   = S_POP_RD1;
      end
      S_POP_RD1: begin
        mem_re   = 1'b1;
        mem_addr = r_sp + ONE;
        w_next   = S_POP_DONE;
      end
      S_POP_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_sp        <= SP_RST;
      r_wide      <= 1'b0;
      r_data      <= '0;
      r_lo        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_next;
      r_rsp_valid <= w_done || (w_accept && !w_ok);
      r_rsp_err   <= w_accept && !w_ok;
      if (w_accept) begin
        r_wide <= req_op[0];
        r_data <= req_data;
      end
      if (mem_we)
        r_sp <= r_sp - ONE;
      else if (mem_re)
        r_sp <= r_sp + ONE;
      // In POP_RD1 the word on mem_rdata is the low half read in POP_RD0.
      if (r_state == S_POP_RD1)
        r_lo <= mem_rdata;
      if (r_state == S_POP_DONE)
        r_rsp_data <= r_wide ? {mem_rdata, r_lo} : {16'h0000, mem_rdata};
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;
  assign sp        = r_sp;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: a reference stack model predicts each
// response, which a monitor pops from a scoreboard queue and compares.
module tb_stack_unit;
  localparam int ADDR_W = 11;
  localparam int TOP    = 2047;
  localparam int LIMIT  = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready;
  logic [1:0]        req_op;
  logic [31:0]       req_data;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_data;
  logic [ADDR_W-1:0] mem_addr, sp;
  logic [15:0]       mem_wdata, mem_rdata;
  logic              mem_we, mem_re;

  always #5 clk = ~clk;

  stack_unit #(.ADDR_W(ADDR_W), .STACK_TOP(TOP), .STACK_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .sp(sp)
  );

  logic [15:0] mem [0:2047];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] m_mem [0:2047];
  int          m_sp = TOP;
  logic [31:0] m_last = '0;
  int          we_cnt = 0;
  int          re_cnt = 0;
  int          snap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model the command, drive it until accepted, queue the predicted response.
  task automatic send(input logic [1:0] op, input logic [31:0] d, input bit hold);
    exp_t e;
    int   n, w;
    bit   ok;
    n = op[0] ? 2 : 1;
    if (!op[1]) begin
      ok = (m_sp - n + 1 >= LIMIT);
      if (ok) begin
        if (n == 2) begin
          m_mem[m_sp]     = d[31:16];
          m_mem[m_sp - 1] = d[15:0];
        end else begin
          m_mem[m_sp] = d[15:0];
        end
        m_sp -= n;
      end
    end else begin
      ok = (TOP - m_sp >= n);
      if (ok) begin
        m_last = (n == 2) ? {m_mem[m_sp + 2], m_mem[m_sp + 1]} : {16'h0000, m_mem[m_sp + 1]};
        m_sp += n;
      end
    end
    e.err  = !ok;
    e.data = m_last;
    e.lat  = !ok ? 1 : (op == 2'd0 ? 2 : (op == 2'd3 ? 4 : 3));
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    if (!hold) req_valid = 1'b0;
    @(negedge clk);
    check("ready_after_accept", 32'(req_ready), 32'(!ok));
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((sb.size() != 0 || !req_ready) && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_data  = '0;
    #1 reset  = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (mem_we) we_cnt++;
        if (mem_re) re_cnt++;
        if (mem_we || mem_re) begin
          check("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
          check("ready_low_busy", 32'(req_ready), 32'd0);
        end
        if (rsp_valid === 1'b1) begin
          if (sb.size() == 0) begin
            check("unexpected_rsp", 32'(rsp_valid), 32'd0);
          end else begin
            mon_e = sb.pop_front();
            check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            check("rsp_data", rsp_data, mon_e.data);
            check("rsp_latency", cyc - mon_e.acc, mon_e.lat - 1);
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_sp", 32'(sp), 32'(TOP));
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);

    send(2'b00, 32'h0000_1234, 1'b0);
    wait_idle();
    check("push16_mem", 32'(mem[2047]), 32'h1234);
    check("push16_sp", 32'(sp), 32'd2046);
    check("idle_addr", 32'(mem_addr), 32'(m_sp));
    send(2'b10, 32'h0, 1'b0);
    wait_idle();
    check("pop16_sp", 32'(sp), 32'd2047);

    send(2'b01, 32'hAABB_CCDD, 1'b0);
    wait_idle();
    check("push32_hi", 32'(mem[2047]), 32'hAABB);
    check("push32_lo", 32'(mem[2046]), 32'hCCDD);
    check("push32_sp", 32'(sp), 32'd2045);
    send(2'b11, 32'h0, 1'b0);
    wait_idle();
    check("pop32_sp", 32'(sp), 32'd2047);

    snap = re_cnt;
    send(2'b10, 32'h0, 1'b0);
    send(2'b11, 32'h0, 1'b0);
    wait_idle();
    check("underflow_no_re", 32'(re_cnt - snap), 32'd0);
    check("underflow_sp", 32'(sp), 32'd2047);

    send(2'b00, 32'h0000_0001, 1'b1);
    send(2'b00, 32'h0000_0002, 1'b1);
    send(2'b10, 32'h0, 1'b1);
    send(2'b10, 32'h0, 1'b0);
    wait_idle();
    check("b2b_sp", 32'(sp), 32'd2047);

    for (int i = 0; i < 511; i++)
      send(2'b01, {16'(i), 16'(i) ^ 16'h5A5A}, 1'b0);
    send(2'b00, 32'h0000_7777, 1'b0);
    wait_idle();
    check("fill_sp", 32'(sp), 32'd1024);
    snap = we_cnt;
    send(2'b01, 32'hDEAD_0001, 1'b0);
    wait_idle();
    check("overflow32_no_we", 32'(we_cnt - snap), 32'd0);
    check("overflow32_sp", 32'(sp), 32'd1024);
    send(2'b00, 32'h0000_BEEF, 1'b0);
    wait_idle();
    check("limit_mem", 32'(mem[1024]), 32'hBEEF);
    check("limit_sp", 32'(sp), 32'd1023);
    snap = we_cnt;
    send(2'b00, 32'h0000_1111, 1'b0);
    wait_idle();
    check("overflow16_no_we", 32'(we_cnt - snap), 32'd0);
    send(2'b10, 32'h0, 1'b0);
    send(2'b10, 32'h0, 1'b0);
    send(2'b11, 32'h0, 1'b0);
    wait_idle();
    check("unwind_sp", 32'(sp), 32'(m_sp));

    // Clean slate, then abandon a POP32 while it is in POP_RD1.
    reset = 1'b0;
    m_sp = TOP;
    m_last = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(2'b01, 32'h1357_2468, 1'b0);
    wait_idle();
    req_valid = 1'b1;
    req_op    = 2'b11;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rd1_addr", 32'(mem_addr), 32'd2047);
    check("rd1_re", 32'(mem_re), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_sp", 32'(sp), 32'd2047);
    check("midrst_rsp_data", rsp_data, 32'd0);
    m_sp = TOP;
    m_last = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(req_ready), 32'd1);
    check("midrst_partial", 32'(mem[2047]), 32'h1357);
    send(2'b10, 32'h0, 1'b0);
    wait_idle();
    check("post_rst_sp", 32'(sp), 32'd2047);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
